// File: rtl/frame_xmtr_pkg.sv
// Shared definitions for the serial frame transmitter: header default,
// counter width, FSM state encoding and the MSB-first bit selector.
package frame_xmtr_pkg;

    localparam logic [7:0] MATCH_DEFAULT = 8'hA5;
    localparam int         COUNT_W       = 3;
    localparam logic [2:0] LAST_COUNT    = 3'd7;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHIFT_HEAD = 2'd1,
        SHIFT_BODY = 2'd2
    } xmtr_state_e;

    // Bit of an octet shown on the line at a given position; count 0 is the MSB.
    function automatic logic frame_bit(input logic [7:0] octet, input logic [2:0] count);
        return octet[3'd7 - count];
    endfunction

endpackage

// File: rtl/frame_xmtr.sv
// Serial frame transmitter: 1-deep holding buffer feeding a gapless
// MSB-first stream of {MATCH header, payload} frames, one bit per clock.
module frame_xmtr
    import frame_xmtr_pkg::*;
#(
    parameter logic [7:0] MATCH = MATCH_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic       ready,
    output logic       overrun,
    output logic       busy,
    output logic       data_out
);

    localparam logic IDLE_BIT = ~MATCH[7];

    xmtr_state_e        state_r;
    logic [COUNT_W-1:0] count_r;
    logic [7:0]         hold_r;
    logic               hold_full_r;
    logic [7:0]         body_r;

    xmtr_state_e        state_nx_s;
    logic [COUNT_W-1:0] count_nx_s;
    logic               load_body_s;
    logic               accept_s;
    logic               refuse_s;
    logic               hold_full_nx_s;
    logic [7:0]         body_nx_s;
    logic               line_nx_s;

    // Next FSM state and count; a frame boundary moves the hold byte into the body.
    always_comb begin
        state_nx_s  = state_r;
        count_nx_s  = count_r;
        load_body_s = 1'b0;
        case (state_r)
            IDLE: begin
                count_nx_s = 3'd0;
                if (hold_full_r) begin
                    state_nx_s  = SHIFT_HEAD;
                    load_body_s = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SHIFT_HEAD: begin
                if (count_r == LAST_COUNT) begin
                    state_nx_s = SHIFT_BODY;
                    count_nx_s = 3'd0;
                end else begin
                    count_nx_s = count_r + 3'd1;
                end
            end
            SHIFT_BODY: begin
                if (count_r == LAST_COUNT) begin
                    count_nx_s = 3'd0;
                    if (hold_full_r) begin
                        state_nx_s  = SHIFT_HEAD;
                        load_body_s = 1'b1;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    count_nx_s = count_r + 3'd1;
                end
            end
            default: begin
                state_nx_s = IDLE;
                count_nx_s = 3'd0;
            end
        endcase
    end

    // Holding-buffer handshake; ready mirrors an empty hold, so no same-edge bypass exists.
    always_comb begin
        accept_s = write & ready;
        refuse_s = write & ~ready;
        if (load_body_s) begin
            hold_full_nx_s = 1'b0;
        end else if (accept_s) begin
            hold_full_nx_s = 1'b1;
        end else begin
            hold_full_nx_s = hold_full_r;
        end
        if (load_body_s) begin
            body_nx_s = hold_r;
        end else begin
            body_nx_s = body_r;
        end
    end

    // Line value for the state being entered, so data_out lines up with state/count.
    always_comb begin
        case (state_nx_s)
            SHIFT_HEAD: line_nx_s = frame_bit(MATCH, count_nx_s);
            SHIFT_BODY: line_nx_s = frame_bit(body_nx_s, count_nx_s);
            IDLE:       line_nx_s = IDLE_BIT;
            default:    line_nx_s = IDLE_BIT;
        endcase
    end

    // All state and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            count_r     <= 3'd0;
            hold_r      <= 8'd0;
            hold_full_r <= 1'b0;
            body_r      <= 8'd0;
            ready       <= 1'b1;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            data_out    <= IDLE_BIT;
        end else begin
            state_r     <= state_nx_s;
            count_r     <= count_nx_s;
            body_r      <= body_nx_s;
            hold_full_r <= hold_full_nx_s;
            ready       <= ~hold_full_nx_s;
            busy        <= (state_nx_s != IDLE);
            data_out    <= line_nx_s;
            if (accept_s) begin
                hold_r  <= data_in;
                overrun <= 1'b0;
            end else if (refuse_s) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
        end
    end

endmodule

// File: tb/tb_frame_xmtr.sv
// Directed bench for frame_xmtr; a small serial receiver model decodes the line.
module tb_frame_xmtr;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       write = 1'b0;
    logic       ready;
    logic       overrun;
    logic       busy;
    logic       data_out;

    int checks = 0;
    int failures = 0;

    frame_xmtr #(.MATCH(8'hA5)) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .write    (write),
        .ready    (ready),
        .overrun  (overrun),
        .busy     (busy),
        .data_out (data_out)
    );

    always #5 clock = ~clock;

    // Receiver model: hunt for the 0xA5 header, then collect 8 payload bits.
    logic [7:0] mon_sr   = 8'd0;
    logic [7:0] mon_body = 8'd0;
    logic       mon_coll = 1'b0;
    logic [2:0] mon_cnt  = 3'd0;
    logic [7:0] rx_q[$];
    int         busy_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            mon_sr   <= 8'd0;
            mon_coll <= 1'b0;
            mon_cnt  <= 3'd0;
        end else if (mon_coll) begin
            mon_body <= {mon_body[6:0], data_out};
            if (mon_cnt == 3'd7) begin
                rx_q.push_back({mon_body[6:0], data_out});
                mon_coll <= 1'b0;
                mon_sr   <= 8'd0;
            end
            mon_cnt <= mon_cnt + 3'd1;
        end else begin
            mon_sr <= {mon_sr[6:0], data_out};
            if ({mon_sr[6:0], data_out} == 8'hA5) begin
                mon_coll <= 1'b1;
                mon_cnt  <= 3'd0;
            end
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rx_word(input int base, input int n);
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < n; i++) begin
            if (base + i < rx_q.size()) w = {w[23:0], rx_q[base + i]};
            else w = {w[23:0], 8'hxx};
        end
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (data_out !== 1'b0) begin failures++; $display("FAIL reset_line got=%b exp=0", data_out); end
    endtask

    task automatic test_single_frame();
        logic [15:0] obs;
        int b0, rb;
        b0 = busy_cnt;
        rb = rx_q.size();
        write = 1'b1; data_in = 8'h3C;
        tick();
        write = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_ready_low got=%b exp=0", ready); end
        for (int i = 0; i < 16; i++) begin
            tick();
            obs[15 - i] = data_out;
        end
        checks++; if (obs !== 16'hA53C) begin failures++; $display("FAIL single_line got=%h exp=a53c", obs); end
        tick();
        checks++; if (data_out !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle line=%b busy=%b exp=0/0", data_out, busy); end
        tick();
        checks++; if (busy_cnt - b0 != 16) begin failures++; $display("FAIL single_busy_len got=%0d exp=16", busy_cnt - b0); end
        checks++; if (rx_q.size() != rb + 1 || rx_word(rb, 1) !== 32'h3C) begin failures++; $display("FAIL single_rx got=%h n=%0d exp=3c", rx_word(rb, 1), rx_q.size() - rb); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready_after got=%b exp=1", ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs;
        int gaps, rb;
        gaps = 0;
        rb = rx_q.size();
        write = 1'b1; data_in = 8'h00;
        tick();
        write = 1'b0;
        tick();
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_reopen got=%b exp=1", ready); end
        for (int i = 0; i < 32; i++) begin
            obs[31 - i] = data_out;
            if (busy !== 1'b1) gaps++;
            if (i == 0) begin write = 1'b1; data_in = 8'hFF; end
            else write = 1'b0;
            tick();
        end
        checks++; if (obs !== 32'hA500A5FF) begin failures++; $display("FAIL b2b_line got=%h exp=a500a5ff", obs); end
        checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_gap got=%0d exp=0", gaps); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end_busy got=%b exp=0", busy); end
        tick();
        checks++; if (rx_q.size() != rb + 2 || rx_word(rb, 2) !== 32'h00FF) begin failures++; $display("FAIL b2b_rx got=%h n=%0d exp=00ff", rx_word(rb, 2), rx_q.size() - rb); end
    endtask

    task automatic test_overrun();
        int n, rb;
        rb = rx_q.size();
        write = 1'b1; data_in = 8'h11;
        tick();
        write = 1'b0;
        tick();
        write = 1'b1; data_in = 8'h22;
        tick();
        data_in = 8'h33;
        tick();
        write = 1'b0;
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        repeat (5) tick();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        n = 0;
        while (ready !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ovr_ready_timeout got=%b exp=1", ready); end
        write = 1'b1; data_in = 8'h44;
        tick();
        write = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        n = 0;
        while (busy !== 1'b0 && n < 80) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_idle_timeout busy=%b exp=0", busy); end
        tick();
        checks++; if (rx_q.size() != rb + 3 || rx_word(rb, 3) !== 32'h112244) begin failures++; $display("FAIL ovr_rx got=%h n=%0d exp=112244", rx_word(rb, 3), rx_q.size() - rb); end
    endtask

    task automatic test_match_payload();
        int rb;
        rb = rx_q.size();
        write = 1'b1; data_in = 8'hA5;
        tick();
        write = 1'b0;
        repeat (18) tick();
        checks++; if (busy !== 1'b0 || data_out !== 1'b0) begin failures++; $display("FAIL match_idle busy=%b line=%b exp=0/0", busy, data_out); end
        repeat (10) tick();
        checks++; if (rx_q.size() != rb + 1 || rx_word(rb, 1) !== 32'hA5) begin failures++; $display("FAIL match_rx got=%h n=%0d exp=a5 n=1", rx_word(rb, 1), rx_q.size() - rb); end
    endtask

    task automatic test_reset_mid_frame();
        int b0, rb;
        rb = rx_q.size();
        write = 1'b1; data_in = 8'h77;
        tick();
        write = 1'b0;
        tick();
        write = 1'b1; data_in = 8'h66;
        tick();
        data_in = 8'h99;
        tick();
        write = 1'b0;
        repeat (9) tick();
        checks++; if (busy !== 1'b1 || data_out !== 1'b1) begin failures++; $display("FAIL mid_body3 busy=%b line=%b exp=1/1", busy, data_out); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL mid_overrun_pre got=%b exp=1", overrun); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (data_out !== 1'b0) begin failures++; $display("FAIL mid_line got=%b exp=0", data_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", ready); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL mid_overrun got=%b exp=0", overrun); end
        b0 = busy_cnt;
        repeat (40) tick();
        checks++; if (busy_cnt != b0) begin failures++; $display("FAIL mid_no_frame busy_cycles=%0d exp=0", busy_cnt - b0); end
        checks++; if (rx_q.size() != rb) begin failures++; $display("FAIL mid_rx_none got=%0d exp=0", rx_q.size() - rb); end
    endtask

    task automatic test_write_held();
        int acc, refused, n, rb;
        acc = 0; refused = 0;
        rb = rx_q.size();
        write = 1'b1; data_in = 8'h5A;
        for (int i = 0; i < 40; i++) begin
            if (ready === 1'b1) acc++;
            else refused++;
            tick();
        end
        write = 1'b0;
        checks++; if (acc != 4) begin failures++; $display("FAIL held_accepts got=%0d exp=4", acc); end
        checks++; if (refused != 36) begin failures++; $display("FAIL held_refused got=%0d exp=36", refused); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL held_overrun got=%b exp=1", overrun); end
        n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL held_idle_timeout busy=%b exp=0", busy); end
        tick();
        checks++; if (rx_q.size() != rb + 4 || rx_word(rb, 4) !== 32'h5A5A5A5A) begin failures++; $display("FAIL held_rx got=%h n=%0d exp=5a5a5a5a", rx_word(rb, 4), rx_q.size() - rb); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_match_payload();
        test_reset_mid_frame();
        test_write_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
